// File: rtl/imem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_pkg                                                             |
// | Shared types and constants for the instruction-memory arbiter.       |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
package imem_pkg;

  typedef enum logic {BOOT, RUN} imem_state_e;

  localparam int IM_ADDR_W = 11;
  localparam int IM_DATA_W = 32;
  localparam int IM_BE_W   = IM_DATA_W / 8;

  localparam logic [31:0] BOOT_PC = 32'h0000_0100;

endpackage
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_arbiter                                                         |
// | Boot loader sequencing and fetch/patch sharing of the imem port.     |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_W,
  parameter int DATA_W = IM_DATA_W,
  parameter int BE_W   = IM_BE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_wdata,
  input  logic [BE_W-1:0]   i_ld_be,
  input  logic              i_ld_last,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic              o_fetch_grant,
  output logic              o_rdata_valid,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [BE_W-1:0]   o_mem_wen,
  output logic              o_core_rst_n,
  output logic              o_boot_done,
  output logic [ADDR_W:0]   o_wr_count
);

  localparam logic [ADDR_W:0] c_CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  imem_state_e       r_state;
  imem_state_e       w_state_nxt;
  logic              r_prio_ld;
  logic              r_rdata_valid;
  logic              r_boot_done;
  logic [ADDR_W:0]   r_wr_count;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              w_fetch_grant;
  logic              w_ld_win;
  logic              w_ld_acc;
  logic              w_contend;
  logic [ADDR_W-1:0] w_mem_addr;

  always_comb begin
    w_state_nxt   = r_state;
    w_fetch_grant = 1'b0;
    w_ld_win      = 1'b0;
    case (r_state)
      BOOT: begin
        w_ld_win = 1'b1;
        if (i_ld_valid && i_ld_last) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (i_fetch_req && !(i_ld_valid && r_prio_ld)) begin
          w_fetch_grant = 1'b1;
        end else begin
          w_ld_win = i_ld_valid;
        end
      end
    endcase
  end

  // Gating with rst_n keeps a write from leaking out while reset is low.
  assign w_ld_acc   = w_ld_win && i_ld_valid && rst_n;
  assign w_contend  = (r_state == RUN) && i_fetch_req && i_ld_valid;
  assign w_mem_addr = w_fetch_grant ? i_fetch_addr :
                      w_ld_acc      ? i_ld_addr    : r_mem_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BOOT;
      r_prio_ld     <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_boot_done   <= 1'b0;
      r_wr_count    <= '0;
      r_mem_addr    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_rdata_valid <= w_fetch_grant;
      r_boot_done   <= (r_state == RUN);
      r_mem_addr    <= w_mem_addr;
      if (w_contend) begin
        r_prio_ld <= w_fetch_grant;
      end
      if (w_ld_acc && (r_wr_count != c_CNT_MAX)) begin
        r_wr_count <= r_wr_count + 1'b1;
      end
    end
  end

  assign o_ld_ready    = w_ld_win && rst_n;
  assign o_fetch_grant = w_fetch_grant;
  assign o_rdata_valid = r_rdata_valid;
  assign o_mem_addr    = w_mem_addr;
  assign o_mem_wdata   = i_ld_wdata;
  assign o_mem_wen     = w_ld_acc ? i_ld_be : '0;
  // Core reset follows the same flop as boot_done so both rise together.
  assign o_core_rst_n  = r_boot_done;
  assign o_boot_done   = r_boot_done;
  assign o_wr_count    = r_wr_count;

endmodule
`default_nettype wire
